// File: rtl/cnf_stream_driver.sv
// cnf_stream_driver: host-side sequencer for the SAT accelerator evaluation port.
// It keeps the formula in a local literal buffer. On start it replays the buffer
// one literal per cycle: resetCNF/resetClause clear the accelerator, enableClause
// streams the literals and enableCNF folds each clause. After a settle delay it
// samples outCNF and reports the result with a one-cycle done pulse.
module cnf_stream_driver #(
  parameter int DEPTH  = 32,
  parameter int VAR_W  = 5,
  parameter int SETTLE = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lit_we,
  input  logic [VAR_W+1:0]         lit_data,
  input  logic                     buf_clr,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     sat_result,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   clause_cnt,
  output logic                     resetCNF,
  output logic                     resetClause,
  output logic                     enableClause,
  output logic                     enableCNF,
  output logic [VAR_W-1:0]         varPos,
  output logic                     negCtrl,
  input  logic                     outCNF
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CNF_CLR, S_CL_CLR, S_LIT, S_FOLD, S_SETTLE, S_DONE
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;       // literals held in the buffer
  logic [CW-1:0]      ptr;         // next buffer entry to issue
  logic               clause_end;  // literal on the port closes its clause
  logic [SW-1:0]      settle_cnt;
  logic [VAR_W+1:0]   mem [DEPTH];
  logic [VAR_W+1:0]   cur_lit;
  logic               cur_end;

  // The entry at ptr, and whether it closes a clause (explicit last bit or end of buffer).
  assign cur_lit = mem[ptr[PW-1:0]];
  assign cur_end = cur_lit[VAR_W+1] || (ptr == count - CW'(1));

  // Buffer occupancy and the sticky overflow flag; the host can only edit while idle.
  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (state == S_IDLE) begin
      if (buf_clr) begin
        count    <= '0;
        overflow <= 1'b0;
      end else if (lit_we) begin
        if (count == CW'(DEPTH)) overflow <= 1'b1;
        else                     count    <= count + CW'(1);
      end
    end
  end

  // Literal storage written at index count.
  // NOTE: the array has no reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && lit_we && !buf_clr && count != CW'(DEPTH))
      mem[count[PW-1:0]] <= lit_data;
  end

  // Sequencer FSM. Each output is registered with the value for the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      ptr          <= '0;
      clause_end   <= 1'b0;
      settle_cnt   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sat_result   <= 1'b0;
      clause_cnt   <= '0;
      resetCNF     <= 1'b0;
      resetClause  <= 1'b0;
      enableClause <= 1'b0;
      enableCNF    <= 1'b0;
      varPos       <= '0;
      negCtrl      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          resetCNF     <= 1'b1;
          resetClause  <= 1'b1;
          enableClause <= 1'b0;
          enableCNF    <= 1'b0;
          if (start) begin
            clause_cnt <= '0;
            if (count == '0) begin
              sat_result <= 1'b1;  // an empty conjunction is true
              done       <= 1'b1;
              state      <= S_DONE;
            end else begin
              busy        <= 1'b1;
              ptr         <= '0;
              resetCNF    <= 1'b0;
              resetClause <= 1'b0;
              state       <= S_CNF_CLR;
            end
          end
        end
        S_CNF_CLR: begin
          resetCNF <= 1'b1;
          state    <= S_CL_CLR;
        end
        S_CL_CLR: begin
          resetClause  <= 1'b1;
          enableClause <= 1'b1;
          varPos       <= cur_lit[VAR_W-1:0];
          negCtrl      <= cur_lit[VAR_W];
          clause_end   <= cur_end;
          ptr          <= ptr + CW'(1);
          state        <= S_LIT;
        end
        S_LIT: begin
          if (clause_end) begin
            enableClause <= 1'b0;
            enableCNF    <= 1'b1;
            if (clause_cnt != {CW{1'b1}}) clause_cnt <= clause_cnt + CW'(1);
            state        <= S_FOLD;
          end else begin
            varPos     <= cur_lit[VAR_W-1:0];
            negCtrl    <= cur_lit[VAR_W];
            clause_end <= cur_end;
            ptr        <= ptr + CW'(1);
          end
        end
        S_FOLD: begin
          enableCNF <= 1'b0;
          if (ptr < count) begin
            resetClause <= 1'b0;
            state       <= S_CL_CLR;
          end else begin
            settle_cnt <= SW'(SETTLE - 1);
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            sat_result <= outCNF;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= S_DONE;
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnf_stream_driver.sv
// tb_cnf_stream_driver: drives formulas into cnf_stream_driver against a small
// behavioural SAT accelerator. Each run's verdict, cycle count and literal stream
// are compared with values computed directly from the formula.
module tb_cnf_stream_driver;

  localparam int DEPTH  = 32;
  localparam int VAR_W  = 5;
  localparam int SETTLE = 2;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int LW     = VAR_W + 2;
  localparam int BUDGET = 300;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              lit_we = 1'b0;
  logic [LW-1:0]     lit_data = '0;
  logic              buf_clr = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, sat_result, overflow;
  logic [CW-1:0]     clause_cnt;
  logic              resetCNF, resetClause, enableClause, enableCNF, negCtrl;
  logic [VAR_W-1:0]  varPos;
  logic              outCNF;

  cnf_stream_driver #(.DEPTH(DEPTH), .VAR_W(VAR_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .lit_we(lit_we), .lit_data(lit_data),
    .buf_clr(buf_clr), .start(start), .busy(busy), .done(done),
    .sat_result(sat_result), .overflow(overflow), .clause_cnt(clause_cnt),
    .resetCNF(resetCNF), .resetClause(resetClause), .enableClause(enableClause),
    .enableCNF(enableCNF), .varPos(varPos), .negCtrl(negCtrl), .outCNF(outCNF)
  );

  always #5 clk = ~clk;

  // Behavioural accelerator: clause accumulates OR of literals, CNF accumulates AND of clauses.
  bit [(1<<VAR_W)-1:0] assign_vec;
  bit acc_cnf, acc_cl;
  always @(posedge clk) begin
    if (!resetCNF)      acc_cnf <= 1'b1;
    else if (enableCNF) acc_cnf <= acc_cnf & acc_cl;
    if (!resetClause)      acc_cl <= 1'b0;
    else if (enableClause) acc_cl <= acc_cl | (assign_vec[varPos] ^ negCtrl);
  end
  assign outCNF = acc_cnf;

  int n_cmp = 0;
  int n_err = 0;

  // Host-side view of the buffer contents.
  logic [LW-1:0] ref_buf[$];
  bit            ref_ovf;

  // Observations from the latest run.
  int            obs_cyc, obs_folds, obs_clclr, obs_cnfclr;
  bit            obs_sat, obs_busy_gap, obs_busy_any, obs_done_after;
  logic [CW-1:0] obs_cnt;
  logic [VAR_W:0] obs_issued[$];

  // Expected run length, clause count and verdict, evaluated straight from the formula.
  function automatic void model_run(output int cyc, output int ncl, output bit sat);
    int n;
    bit cl;
    n = ref_buf.size();
    ncl = 0; sat = 1'b1; cl = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic [LW-1:0] l;
      l = ref_buf[i];
      cl = cl | (assign_vec[l[VAR_W-1:0]] ^ l[VAR_W]);
      if (l[LW-1] || i == n - 1) begin
        ncl++;
        sat = sat & cl;
        cl = 1'b0;
      end
    end
    cyc = (n == 0) ? 1 : 2 + n + 2 * ncl - 1 + SETTLE + 1;
  endfunction

  // Positions where the streamed {neg,var} differs from the buffer, plus one for a length mismatch.
  function automatic int seq_errs();
    int e;
    e = (obs_issued.size() != ref_buf.size()) ? 1 : 0;
    for (int i = 0; i < obs_issued.size() && i < ref_buf.size(); i++)
      if (obs_issued[i] !== ref_buf[i][VAR_W:0]) e++;
    return e;
  endfunction

  task automatic host_write(input logic [LW-1:0] d);
    @(negedge clk); lit_we = 1'b1; lit_data = d;
    @(negedge clk); lit_we = 1'b0;
    if (ref_buf.size() < DEPTH) ref_buf.push_back(d);
    else                        ref_ovf = 1'b1;
  endtask

  task automatic host_clear();
    @(negedge clk); buf_clr = 1'b1;
    @(negedge clk); buf_clr = 1'b0;
    ref_buf.delete();
    ref_ovf = 1'b0;
  endtask

  task automatic rand_lit(input bit force_last, output logic [LW-1:0] d);
    bit [31:0] r;
    r = $urandom();
    d = {force_last | (r[31:30] == 2'b00), r[VAR_W], r[VAR_W-1:0]};
  endtask

  // Pulse start and watch each cycle until done; optionally poke start/lit_we mid-run.
  task automatic run_formula(input bit disturb);
    bit [31:0] r;
    obs_issued.delete();
    obs_folds = 0; obs_clclr = 0; obs_cnfclr = 0; obs_cyc = -1;
    obs_busy_gap = 1'b0; obs_busy_any = 1'b0; obs_sat = 1'b0; obs_cnt = '0;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      start = 1'b0; lit_we = 1'b0;
      if (disturb && k == 3) begin
        r = $urandom();
        start = 1'b1; lit_we = 1'b1; lit_data = r[LW-1:0];
      end
      if (busy) obs_busy_any = 1'b1;
      if (enableClause) obs_issued.push_back({negCtrl, varPos});
      if (enableCNF) obs_folds++;
      if (!resetClause && resetCNF) obs_clclr++;
      if (!resetCNF) obs_cnfclr++;
      if (done) begin
        obs_cyc = k; obs_sat = sat_result; obs_cnt = clause_cnt;
        if (busy) obs_busy_gap = 1'b1;
        break;
      end
      if (!busy) obs_busy_gap = 1'b1;
    end
    start = 1'b0; lit_we = 1'b0;
    @(negedge clk);
    obs_done_after = done;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({busy, done, sat_result, overflow, clause_cnt, resetCNF, resetClause,
         enableClause, enableCNF, varPos, negCtrl} !== '0) begin
      n_err++;
      $display("FAIL reset_values: got busy=%b done=%b sat=%b ovf=%b cnt=%0d rc=%b rcl=%b ec=%b en=%b vp=%0d neg=%b want all 0",
               busy, done, sat_result, overflow, clause_cnt, resetCNF, resetClause,
               enableClause, enableCNF, varPos, negCtrl);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({resetCNF, resetClause, busy} !== 3'b110) begin
      n_err++;
      $display("FAIL idle_levels: got rc=%b rcl=%b busy=%b want 1 1 0", resetCNF, resetClause, busy);
    end
  endtask

  task automatic test_single_clause();
    int ec, encl; bit es;
    host_clear();
    assign_vec = {$urandom(), $urandom()};
    assign_vec[1] = 1'b1;
    host_write({1'b0, 1'b0, 5'd1});
    host_write({1'b0, 1'b1, 5'd2});
    host_write({1'b1, 1'b0, 5'd3});
    model_run(ec, encl, es);
    run_formula(1'b0);
    n_cmp++; if (obs_cyc !== 9) begin n_err++; $display("FAIL single_done_cycle: got %0d want 9", obs_cyc); end
    n_cmp++; if (seq_errs() !== 0) begin n_err++; $display("FAIL single_lit_seq: %0d errors want 0", seq_errs()); end
    n_cmp++; if (obs_folds !== 1) begin n_err++; $display("FAIL single_folds: got %0d want 1", obs_folds); end
    n_cmp++; if (obs_sat !== 1'b1) begin n_err++; $display("FAIL single_sat: got %b want 1", obs_sat); end
    n_cmp++; if (obs_cnt !== CW'(1)) begin n_err++; $display("FAIL single_clause_cnt: got %0d want 1", obs_cnt); end
    n_cmp++; if ({obs_busy_gap, obs_done_after} !== 2'b00) begin n_err++; $display("FAIL single_busy_done: gap=%b done_after=%b want 0 0", obs_busy_gap, obs_done_after); end
    n_cmp++; if (obs_cnfclr !== 1) begin n_err++; $display("FAIL single_cnf_clear: got %0d want 1", obs_cnfclr); end
  endtask

  task automatic test_two_clauses();
    int ec, encl; bit es;
    host_clear();
    assign_vec = '0;
    host_write({1'b0, 1'b0, 5'd1});
    host_write({1'b1, 1'b0, 5'd2});
    host_write({1'b1, 1'b0, 5'd3});
    model_run(ec, encl, es);
    run_formula(1'b0);
    n_cmp++; if (obs_cyc !== ec) begin n_err++; $display("FAIL two_done_cycle: got %0d want %0d", obs_cyc, ec); end
    n_cmp++; if (obs_clclr !== 2) begin n_err++; $display("FAIL two_clause_clears: got %0d want 2", obs_clclr); end
    n_cmp++; if (obs_folds !== 2) begin n_err++; $display("FAIL two_folds: got %0d want 2", obs_folds); end
    n_cmp++; if (obs_sat !== 1'b0) begin n_err++; $display("FAIL two_sat: got %b want 0", obs_sat); end
    n_cmp++; if (obs_cnt !== CW'(2)) begin n_err++; $display("FAIL two_clause_cnt: got %0d want 2", obs_cnt); end
  endtask

  task automatic test_empty(input string name);
    run_formula(1'b0);
    n_cmp++; if (obs_cyc !== 1) begin n_err++; $display("FAIL %s_done_cycle: got %0d want 1", name, obs_cyc); end
    n_cmp++; if (obs_sat !== 1'b1) begin n_err++; $display("FAIL %s_sat: got %b want 1", name, obs_sat); end
    n_cmp++; if (obs_issued.size() + obs_folds + obs_cnfclr !== 0) begin n_err++; $display("FAIL %s_pulses: got %0d want 0", name, obs_issued.size() + obs_folds + obs_cnfclr); end
    n_cmp++; if (obs_busy_any !== 1'b0) begin n_err++; $display("FAIL %s_busy: got %b want 0", name, obs_busy_any); end
    n_cmp++; if (obs_cnt !== '0) begin n_err++; $display("FAIL %s_clause_cnt: got %0d want 0", name, obs_cnt); end
  endtask

  task automatic test_overflow();
    logic [LW-1:0] d;
    int ec, encl; bit es;
    host_clear();
    assign_vec = {$urandom(), $urandom()};
    for (int i = 0; i < DEPTH + 1; i++) begin
      rand_lit(1'b0, d);
      host_write(d);
    end
    n_cmp++; if (overflow !== ref_ovf) begin n_err++; $display("FAIL ovf_set: got %b want %b", overflow, ref_ovf); end
    model_run(ec, encl, es);
    run_formula(1'b0);
    n_cmp++; if (seq_errs() !== 0) begin n_err++; $display("FAIL ovf_full_seq: %0d errors, issued %0d want %0d", seq_errs(), obs_issued.size(), DEPTH); end
    n_cmp++; if (obs_cyc !== ec) begin n_err++; $display("FAIL ovf_done_cycle: got %0d want %0d", obs_cyc, ec); end
    n_cmp++; if (obs_cnt !== CW'(encl)) begin n_err++; $display("FAIL ovf_clause_cnt: got %0d want %0d", obs_cnt, encl); end
    host_clear();
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    host_write({1'b1, 1'b0, 5'd4});
    host_write({1'b1, 1'b1, 5'd5});
    @(negedge clk); lit_we = 1'b1; buf_clr = 1'b1; lit_data = {1'b1, 1'b0, 5'd6};
    @(negedge clk); lit_we = 1'b0; buf_clr = 1'b0;
    ref_buf.delete();
    test_empty("clr_wins");
  endtask

  task automatic test_implicit_end();
    int ec, encl; bit es;
    host_clear();
    assign_vec = {$urandom(), $urandom()};
    host_write({1'b1, 1'b1, 5'd7});
    host_write({1'b0, 1'b0, 5'd8});
    host_write({1'b0, 1'b1, 5'd9});
    model_run(ec, encl, es);
    run_formula(1'b0);
    n_cmp++; if (obs_folds !== 2) begin n_err++; $display("FAIL implicit_folds: got %0d want 2", obs_folds); end
    n_cmp++; if (obs_cyc !== ec) begin n_err++; $display("FAIL implicit_done_cycle: got %0d want %0d", obs_cyc, ec); end
    n_cmp++; if (obs_sat !== es) begin n_err++; $display("FAIL implicit_sat: got %b want %b", obs_sat, es); end
  endtask

  task automatic test_ignore_during_run();
    logic [LW-1:0] d;
    int ec, encl; bit es;
    host_clear();
    assign_vec = {$urandom(), $urandom()};
    for (int i = 0; i < 5; i++) begin
      rand_lit(i == 4, d);
      host_write(d);
    end
    model_run(ec, encl, es);
    run_formula(1'b1);
    n_cmp++; if (obs_cyc !== ec) begin n_err++; $display("FAIL disturb_done_cycle: got %0d want %0d", obs_cyc, ec); end
    n_cmp++; if (seq_errs() !== 0) begin n_err++; $display("FAIL disturb_seq: %0d errors want 0", seq_errs()); end
    // A second start alone replays the same retained formula.
    run_formula(1'b0);
    n_cmp++; if (obs_cyc !== ec) begin n_err++; $display("FAIL rerun_done_cycle: got %0d want %0d", obs_cyc, ec); end
    n_cmp++; if (seq_errs() !== 0) begin n_err++; $display("FAIL rerun_seq: %0d errors want 0", seq_errs()); end
    n_cmp++; if (obs_sat !== es) begin n_err++; $display("FAIL rerun_sat: got %b want %b", obs_sat, es); end
  endtask

  task automatic test_random();
    logic [LW-1:0] d;
    int ec, encl, n; bit es;
    for (int it = 0; it < 15; it++) begin
      host_clear();
      assign_vec = {$urandom(), $urandom()};
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        rand_lit(1'b0, d);
        host_write(d);
      end
      model_run(ec, encl, es);
      run_formula(1'b0);
      n_cmp++; if (obs_cyc !== ec) begin n_err++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", it, obs_cyc, ec); end
      n_cmp++; if (seq_errs() !== 0) begin n_err++; $display("FAIL rand%0d_seq: %0d errors want 0", it, seq_errs()); end
      n_cmp++; if (obs_folds !== encl) begin n_err++; $display("FAIL rand%0d_folds: got %0d want %0d", it, obs_folds, encl); end
      n_cmp++; if (obs_sat !== es) begin n_err++; $display("FAIL rand%0d_sat: got %b want %b", it, obs_sat, es); end
      n_cmp++; if (obs_cnt !== CW'(encl)) begin n_err++; $display("FAIL rand%0d_clause_cnt: got %0d want %0d", it, obs_cnt, encl); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [LW-1:0] d;
    bit seen;
    host_clear();
    for (int i = 0; i < 6; i++) begin
      rand_lit(1'b0, d);
      host_write(d);
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = enableClause;
    end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL midrun_reach_lit: got %b want 1", seen); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, sat_result, overflow, clause_cnt, resetCNF, resetClause,
         enableClause, enableCNF, varPos, negCtrl} !== '0) begin
      n_err++;
      $display("FAIL midrun_reset_values: got busy=%b ec=%b rc=%b rcl=%b vp=%0d cnt=%0d want all 0",
               busy, enableClause, resetCNF, resetClause, varPos, clause_cnt);
    end
    @(negedge clk); reset = 1'b0;
    ref_buf.delete();
    ref_ovf = 1'b0;
    test_empty("post_reset");
  endtask

  initial begin
    test_reset();
    test_single_clause();
    test_two_clauses();
    host_clear();
    test_empty("empty");
    test_overflow();
    test_implicit_end();
    test_ignore_during_run();
    test_random();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cnf_stream_driver.md
Name: cnf_stream_driver

Overview:
- Host-side sequencer that drives a CNF formula into the SAT_accelerator evaluation port, one literal per cycle, and collects the verdict.
- Holds the formula in a local literal buffer.
- Generates resetCNF/resetClause/enableClause/enableCNF/varPos/negCtrl in the order the accelerator consumes them.
- Samples outCNF after a settle delay and returns a single result with a done pulse.

Parameters:
DEPTH, 32, literal buffer entries (power of 2, ≥2)
VAR_W, 5, varPos width; matches accelerator
SETTLE, 2, cycles between last enableCNF pulse and outCNF sample (≥1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
lit_we  in  1  host literal write strobe
lit_data  in  VAR_W+2  {last, neg, var}; last=1 marks final literal of a clause
buf_clr  in  1  empties the literal buffer (idle only)
start  in  1  begin evaluation of the buffered formula
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when sat_result is valid
sat_result  out  1  sampled outCNF, held until next start
overflow  out  1  sticky; write attempted while buffer full
clause_cnt  out  $clog2(DEPTH)+1  clauses folded in the last run
resetCNF  out  1  to accelerator; active-low clear of CNF accumulator
resetClause  out  1  to accelerator; active-low clear of clause accumulator
enableClause  out  1  to accelerator; literal valid this cycle
enableCNF  out  1  to accelerator; fold current clause into CNF
varPos  out  VAR_W  to accelerator; variable index of current literal
negCtrl  out  1  to accelerator; literal is negated
outCNF  in  1  from accelerator; formula result

Behaviour:
- Reset values: busy=0, done=0, sat_result=0, overflow=0, clause_cnt=0, resetCNF=0, resetClause=0, enableClause=0, enableCNF=0, varPos=0, negCtrl=0. Buffer count=0, read pointer=0, FSM=IDLE.
- Buffer writes:
  - lit_we in IDLE with count<DEPTH stores at index count and increments count.
  - At count=DEPTH the write is dropped and overflow is set.
  - lit_we while busy is ignored; it does not set overflow.
  - buf_clr in IDLE zeroes count and overflow. buf_clr while busy is ignored.
  - lit_we and buf_clr in the same cycle: buf_clr wins.
  - Buffer contents are retained across runs, so re-running the same formula needs only start.
- FSM, one state per cycle unless noted:
  - IDLE: resetCNF=1, resetClause=1, all enables 0.
    - start with count=0: go to DONE, sat_result=1 (empty CNF is true), clause_cnt=0, no accelerator pulses.
    - start with count>0: go to CNF_CLR, busy=1, read pointer=0, clause_cnt=0.
    - start while busy is ignored.
  - CNF_CLR: resetCNF=0, resetClause=0. Next state CL_CLR.
  - CL_CLR: resetCNF=1, resetClause=0. Next state LIT.
  - LIT: resetClause=1, enableClause=1; varPos/negCtrl come from buffer[ptr]; ptr increments each cycle.
    - Stays in LIT while the literal's last=0 and ptr<count-1.
    - Goes to FOLD when last=1 or ptr=count-1; the final buffered literal is an implicit clause end even if its last=0.
  - FOLD: enableClause=0, enableCNF=1, clause_cnt increments.
    - More literals remain: go to CL_CLR.
    - Otherwise: go to SETTLE.
  - SETTLE: all enables 0 for SETTLE cycles. Then sample outCNF into sat_result and go to DONE.
  - DONE: done=1 for one cycle, busy=0. Next state IDLE.
- Timing: run length = 2 + Σ(literals_i + 2) − 1 + SETTLE + 1 cycles from start to done.
  - Example: one 3-literal clause, SETTLE=2 → start at cycle 0, done at cycle 9.
- varPos and negCtrl hold their last value when enableClause=0.
- Asynchronous reset mid-run: returns immediately to reset values and discards the buffer.
- clause_cnt saturates at its maximum; it cannot wrap for DEPTH literals.

Test Plan:
- Write 3 literals {0,0,1},{0,1,2},{1,0,3}, start; accelerator model with outCNF=1 → exactly one enableCNF pulse, varPos sequence 1,2,3, negCtrl 0,1,0, done at cycle 9, sat_result=1, clause_cnt=1.
- Two clauses (2 literals + 1 literal), model returns outCNF=0 → resetClause low once before each clause, two enableCNF pulses, sat_result=0, clause_cnt=2.
- Start with empty buffer → done the next cycle, sat_result=1, no enable pulses, busy stays low.
- Write DEPTH+1 literals → overflow=1, count=DEPTH; buf_clr → overflow=0; lit_we+buf_clr in the same cycle → buffer empty.
- Final literal written with last=0 → FOLD still occurs after it; start and lit_we during a run are ignored (count and pointer unchanged).
- Assert reset during LIT → all outputs at reset values within the same cycle, FSM=IDLE, a subsequent start with empty buffer behaves as the empty case.
